tomasulo_cdb_sched: RTL and testbench
=====================================

TOMASULO_CDB_SCHED -- requirements
Module: tomasulo_cdb_sched

Interface
REQ-001 Parameter REQ_N, default 4: number of reservation-station requesters.
REQ-002 Parameter SCH_W, default 8: CDB reservation horizon in cycles; slot k of the schedule vector = CDB occupied k cycles from now.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 req  input  REQ_N  per-requester CDB slot request (the RS cdb_req).
REQ-006 lat  input  REQ_N x clog2(SCH_W)  per-requester execution latency in cycles; quasi-static, legal range 1..SCH_W-1.
REQ-007 flush  input  1  discard all outstanding CDB reservations.
REQ-008 gnt  output  REQ_N  one-hot (or zero) grant, combinational, same cycle as req (the RS cdb_gnt).
REQ-009 sch_r  output  SCH_W  registered reservation vector, broadcast to all requesters (the RS sch_r).
REQ-010 cdb_own_vld  output  1  CDB owned this cycle; equals sch_r[0].
REQ-011 cdb_own_id  output  clog2(REQ_N)  index of the requester whose result drives the CDB this cycle; 0 when cdb_own_vld=0.
REQ-012 err_r  output  1  sticky error flag; set on request with illegal latency.

Function
REQ-013 Eligibility: requester i eligible iff req[i]=1, lat[i] in 1..SCH_W-1, sch_r[lat[i]]=0, flush=0.
REQ-014 At most one grant per cycle; winner selected round-robin among eligible requesters, search starting at rr_ptr_r.
REQ-015 On grant to i: rr_ptr_r <= (i+1) mod REQ_N; with no grant, rr_ptr_r holds.
REQ-016 Shift each cycle: sch_r[k] <= sch_r[k+1] for k<SCH_W-1; sch_r[SCH_W-1] <= 0.
REQ-017 On grant to i with latency L: sch_r[L-1] <= 1 and own_r[L-1] <= i, overriding the shift for that slot only.
REQ-018 Owner pipeline own_r shifts in lockstep with sch_r; own_r[SCH_W-1] <= 0; own_r[k] = 0 wherever sch_r[k] = 0.
REQ-019 End-to-end latency: grant in cycle t with latency L -> cdb_own_vld=1 and cdb_own_id=i in cycle t+L exactly.
REQ-020 No double booking: a slot already set is never granted again; two requesters with equal latency in the same cycle -> only the round-robin winner is granted; the loser is eligible again next cycle if its slot is free.
REQ-021 Requesters with different latencies contend only for the single grant per cycle; the non-winner retries.
REQ-022 Illegal latency (0 or >= SCH_W) with req[i]=1: never granted; err_r <= 1 and stays set until reset.
REQ-023 Flush: gnt=0 in the flush cycle; next cycle sch_r=0, own_r=0, cdb_own_vld=0; rr_ptr_r holds; err_r unaffected.
REQ-024 req deassertion is permitted at any time; a grant is issued only in a cycle where req is high.
REQ-025 Invariant: popcount(gnt) <= 1; gnt[i] implies req[i].

Reset
REQ-026 While rst_n=0: sch_r=0, own_r=0, rr_ptr_r=0, err_r=0, cdb_own_vld=0, cdb_own_id=0, gnt forced to 0 regardless of req.
REQ-027 Reset assertion mid-operation discards all reservations immediately (asynchronous); the first grant is possible in the first cycle after deassertion.

Verification
REQ-028 Single request: REQ_N=4, req=0001, lat[0]=3 at cycle 10 -> gnt=0001 at cycle 10, sch_r=00000100 at cycle 11, cdb_own_vld=1 with id 0 at cycle 13 only.
REQ-029 Round-robin fairness: req=1111 held, all lat=1 -> grants 0001, 0010, 0100, 1000, 0001 in successive cycles; CDB ids 0,1,2,3,0 one cycle later.
REQ-030 Slot collision: cycle 0 grant req0 lat=4; cycle 2 req1 lat=2 -> gnt=0 at cycle 2 (slot 2 busy), gnt to req1 at cycle 3; CDB ids 0 at cycle 4, 1 at cycle 5.
REQ-031 Illegal latency: req=0010, lat[1]=0 -> gnt=0 indefinitely, err_r=1 from the next cycle, held until rst_n low.
REQ-032 Flush: three reservations outstanding, flush=1 with req=0001 -> gnt=0 that cycle; sch_r=0 and cdb_own_vld=0 next cycle; req0 granted the cycle after.
REQ-033 Async reset: rst_n driven low between edges with sch_r nonzero -> sch_r, cdb_own_vld and gnt go to 0 without waiting for a clock edge.

Source files
------------

// File: rtl/tomasulo_cdb_sched_if.sv
// Request/grant and reservation-broadcast bundle between the reservation
// stations (master) and the CDB slot scheduler (slave).
interface tomasulo_cdb_sched_if #(
  parameter int unsigned REQ_N = 4,
  parameter int unsigned SCH_W = 8
);
  localparam int unsigned LW = (SCH_W > 1) ? $clog2(SCH_W) : 1;
  localparam int unsigned IW = (REQ_N > 1) ? $clog2(REQ_N) : 1;

  logic [REQ_N-1:0]         req;
  logic [REQ_N-1:0][LW-1:0] lat;
  logic                     flush;
  logic [REQ_N-1:0]         gnt;
  logic [SCH_W-1:0]         sch_r;
  logic                     cdb_own_vld;
  logic [IW-1:0]            cdb_own_id;
  logic                     err_r;

  modport master (
    output req, lat, flush,
    input  gnt, sch_r, cdb_own_vld, cdb_own_id, err_r
  );

  modport slave (
    input  req, lat, flush,
    output gnt, sch_r, cdb_own_vld, cdb_own_id, err_r
  );
endinterface

// File: rtl/tomasulo_cdb_sched.sv
// CDB slot scheduler: reservation stations book the common data bus L cycles
// ahead; a round-robin arbiter issues at most one booking per cycle into a
// shifting reservation vector with a parallel owner pipeline.
module tomasulo_cdb_sched #(
  parameter int unsigned REQ_N = 4,
  parameter int unsigned SCH_W = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  tomasulo_cdb_sched_if.slave  bus
);
  localparam int unsigned LW = (SCH_W > 1) ? $clog2(SCH_W) : 1;
  localparam int unsigned IW = (REQ_N > 1) ? $clog2(REQ_N) : 1;

  logic [SCH_W-1:0]         sch_q, sch_d;
  logic [SCH_W-1:0][IW-1:0] own_q, own_d;
  logic [IW-1:0]            rr_ptr_q, rr_ptr_d;
  logic                     err_q, err_d;

  logic [REQ_N-1:0] legal;
  logic [REQ_N-1:0] elig;
  logic [REQ_N-1:0] gnt;
  logic             win_vld;
  logic [IW-1:0]    win_id;
  logic [LW-1:0]    win_lat;
  logic [IW-1:0]    idx;

  // Per-requester latency legality and eligibility (slot lat[i] must be free).
  always_comb begin
    legal = '0;
    elig  = '0;
    for (int unsigned i = 0; i < REQ_N; i++) begin
      legal[i] = (bus.lat[i] != '0) && (32'(bus.lat[i]) < SCH_W);
      elig[i]  = rst_n && bus.req[i] && legal[i] && !bus.flush
                 && !sch_q[bus.lat[i]];
    end
  end

  // Round-robin pick: first eligible requester at or after rr_ptr_q.
  always_comb begin
    win_vld = 1'b0;
    win_id  = '0;
    idx     = '0;
    gnt     = '0;
    for (int unsigned j = 0; j < REQ_N; j++) begin
      idx = IW'((32'(rr_ptr_q) + j) % REQ_N);
      if (!win_vld && elig[idx]) begin
        win_vld = 1'b1;
        win_id  = idx;
      end
    end
    if (win_vld) gnt[win_id] = 1'b1;
    win_lat = bus.lat[win_id];
  end

  // Next state: shift schedule and owners, book the winner's slot, track errors.
  always_comb begin
    sch_d    = {1'b0, sch_q[SCH_W-1:1]};
    own_d    = {{IW{1'b0}}, own_q[SCH_W-1:1]};
    rr_ptr_d = rr_ptr_q;
    err_d    = err_q | (|(bus.req & ~legal));
    if (bus.flush) begin
      sch_d = '0;
      own_d = '0;
    end else if (win_vld) begin
      // Booking lands one below L because the vector shifts in the same edge.
      sch_d[win_lat - LW'(1)] = 1'b1;
      own_d[win_lat - LW'(1)] = win_id;
      rr_ptr_d = IW'((32'(win_id) + 1) % REQ_N);
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sch_q    <= '0;
      own_q    <= '0;
      rr_ptr_q <= '0;
      err_q    <= 1'b0;
    end else begin
      sch_q    <= sch_d;
      own_q    <= own_d;
      rr_ptr_q <= rr_ptr_d;
      err_q    <= err_d;
    end
  end

  assign bus.gnt         = gnt;
  assign bus.sch_r       = sch_q;
  assign bus.cdb_own_vld = sch_q[0];
  assign bus.cdb_own_id  = own_q[0];
  assign bus.err_r       = err_q;
endmodule

// File: tb/tb_tomasulo_cdb_sched.sv
// Bench for tomasulo_cdb_sched: directed grant vectors checked in the stimulus
// thread; expected CDB ownership events queued and checked by a monitor.
module tb_tomasulo_cdb_sched;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int unsigned cyc = 0;
  int checks = 0;
  int errors = 0;

  typedef struct {
    int unsigned cyc;
    logic [1:0]  id;
  } ev_t;
  ev_t exp_q[$];

  tomasulo_cdb_sched_if #(.REQ_N(4), .SCH_W(8)) bus ();

  tomasulo_cdb_sched #(.REQ_N(4), .SCH_W(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic logic [3:0][2:0] mk_lat(input int a0, input int a1, input int a2, input int a3);
    logic [3:0][2:0] l;
    l[0] = 3'(a0); l[1] = 3'(a1); l[2] = 3'(a2); l[3] = 3'(a3);
    return l;
  endfunction

  // One cycle: drive inputs, check gnt mid-cycle, queue the expected CDB event.
  task automatic step(input logic [3:0] r, input logic [3:0][2:0] l, input logic f,
                      input logic [3:0] exp_gnt, input string nm);
    ev_t e;
    bus.req = r;
    bus.lat = l;
    bus.flush = f;
    @(negedge clk);
    check(nm, 32'(bus.gnt), 32'(exp_gnt));
    for (int i = 0; i < 4; i++) begin
      if (exp_gnt[i]) begin
        e.cyc = cyc + 32'(l[i]);
        e.id  = 2'(i);
        exp_q.push_back(e);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(4'b0000, mk_lat(1, 1, 1, 1), 1'b0, 4'b0000, "gnt_idle");
  endtask

  // Monitor: every CDB ownership must match the head of the expected queue.
  always @(negedge clk) begin
    ev_t e;
    if (rst_n) begin
      if (bus.cdb_own_vld) begin
        if (exp_q.size() == 0) begin
          check("cdb_unexpected", 32'(bus.cdb_own_vld), 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("cdb_cycle", cyc, e.cyc);
          check("cdb_id", 32'(bus.cdb_own_id), 32'(e.id));
        end
      end else begin
        check("cdb_id_idle", 32'(bus.cdb_own_id), 32'd0);
        if (exp_q.size() != 0 && exp_q[0].cyc <= cyc) begin
          e = exp_q.pop_front();
          check("cdb_missing", 32'd0, 32'd1);
        end
      end
    end
  end

  initial begin
    bus.req = 4'b1111;
    bus.lat = mk_lat(1, 1, 1, 1);
    bus.flush = 1'b0;

    // Reset state with requests pending
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_gnt", 32'(bus.gnt), 32'd0);
    check("rst_sch", 32'(bus.sch_r), 32'd0);
    check("rst_vld", 32'(bus.cdb_own_vld), 32'd0);
    check("rst_id", 32'(bus.cdb_own_id), 32'd0);
    check("rst_err", 32'(bus.err_r), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Round-robin fairness, all lat=1
    step(4'b1111, mk_lat(1, 1, 1, 1), 1'b0, 4'b0001, "rr_g0");
    step(4'b1111, mk_lat(1, 1, 1, 1), 1'b0, 4'b0010, "rr_g1");
    step(4'b1111, mk_lat(1, 1, 1, 1), 1'b0, 4'b0100, "rr_g2");
    step(4'b1111, mk_lat(1, 1, 1, 1), 1'b0, 4'b1000, "rr_g3");
    step(4'b1111, mk_lat(1, 1, 1, 1), 1'b0, 4'b0001, "rr_g4");
    idle(2);

    // Single request lat=3
    step(4'b0001, mk_lat(3, 1, 1, 1), 1'b0, 4'b0001, "single_gnt");
    check("single_sch", 32'(bus.sch_r), 32'h04);
    idle(4);

    // Slot collision: lat4 booking blocks a later lat2 request for one cycle
    step(4'b0001, mk_lat(4, 1, 1, 1), 1'b0, 4'b0001, "coll_g0");
    idle(1);
    step(4'b0010, mk_lat(1, 2, 1, 1), 1'b0, 4'b0000, "coll_busy");
    step(4'b0010, mk_lat(1, 2, 1, 1), 1'b0, 4'b0010, "coll_g1");
    idle(3);

    // Equal latency contention: winner now, loser next cycle
    step(4'b0011, mk_lat(2, 2, 1, 1), 1'b0, 4'b0001, "eq_win");
    step(4'b0011, mk_lat(2, 2, 1, 1), 1'b0, 4'b0010, "eq_retry");
    idle(3);

    // Flush with three reservations outstanding
    step(4'b0001, mk_lat(5, 6, 7, 1), 1'b0, 4'b0001, "fl_r0");
    step(4'b0010, mk_lat(5, 6, 7, 1), 1'b0, 4'b0010, "fl_r1");
    step(4'b0100, mk_lat(5, 6, 7, 1), 1'b0, 4'b0100, "fl_r2");
    bus.req = 4'b0001;
    bus.lat = mk_lat(5, 6, 7, 1);
    bus.flush = 1'b1;
    @(negedge clk);
    check("fl_gnt", 32'(bus.gnt), 32'd0);
    exp_q.delete();
    @(posedge clk);
    #1;
    check("fl_sch", 32'(bus.sch_r), 32'd0);
    check("fl_vld", 32'(bus.cdb_own_vld), 32'd0);
    step(4'b0001, mk_lat(5, 6, 7, 1), 1'b0, 4'b0001, "fl_after");
    idle(6);

    // Illegal latency
    check("err_pre", 32'(bus.err_r), 32'd0);
    step(4'b0010, mk_lat(1, 0, 1, 1), 1'b0, 4'b0000, "ill_g0");
    check("err_set", 32'(bus.err_r), 32'd1);
    step(4'b0010, mk_lat(1, 0, 1, 1), 1'b0, 4'b0000, "ill_g1");
    step(4'b0010, mk_lat(1, 0, 1, 1), 1'b0, 4'b0000, "ill_g2");
    idle(2);
    check("err_hold", 32'(bus.err_r), 32'd1);

    // Asynchronous reset with a reservation outstanding
    step(4'b0001, mk_lat(4, 1, 1, 1), 1'b0, 4'b0001, "ar_book");
    check("ar_sch_pre", 32'(bus.sch_r), 32'h08);
    #2;
    bus.lat = mk_lat(1, 1, 1, 1);
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    check("ar_sch", 32'(bus.sch_r), 32'd0);
    check("ar_vld", 32'(bus.cdb_own_vld), 32'd0);
    check("ar_gnt", 32'(bus.gnt), 32'd0);
    check("ar_err", 32'(bus.err_r), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step(4'b0001, mk_lat(1, 1, 1, 1), 1'b0, 4'b0001, "ar_first");
    idle(2);

    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
